// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the multiply sequencer and the datapath ALU:
// ALU control codes and the sequencer state encoding.
package mul_sequencer_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_MOVZ  = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mul_sequencer.sv
// Shift-and-add unsigned multiplier (low WIDTH bits) that borrows the
// shared datapath ALU for one ADD per iteration instead of a multiplier array.
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNTW  = 7
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] MulA,
    input  logic [WIDTH-1:0] MulB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Product,
    output logic             ALUOwn,
    output logic [3:0]       ALUCtrlOut,
    output logic [WIDTH-1:0] ALUBusA,
    output logic [WIDTH-1:0] ALUBusB,
    input  logic [WIDTH-1:0] ALUBusW
);

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_m;
    logic [WIDTH-1:0]  r_q;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_product;
    logic [CNTW-1:0]   r_count;
    logic [WIDTH-1:0]  w_q_shr;
    logic [CNTW-1:0]   w_count_inc;
    logic              w_last;
    logic              w_run;

    assign w_q_shr     = r_q >> 1;
    assign w_count_inc = r_count + CNTW'(1);
    // Stop once no multiplier bits remain or every bit position has been used.
    assign w_last      = (w_q_shr == '0) || (w_count_inc == CNTW'(WIDTH));
    assign w_run       = (r_state == ST_RUN);
    assign Product     = r_product;

    // State register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded outputs, ALU buses zeroed outside RUN.
    always_comb begin
        w_state_next = r_state;
        Busy         = 1'b0;
        ALUOwn       = 1'b0;
        Done         = 1'b0;
        ALUCtrlOut   = ALU_ADD;
        ALUBusA      = '0;
        ALUBusB      = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_state_next = (MulB == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                Busy    = 1'b1;
                ALUOwn  = 1'b1;
                ALUBusA = r_acc;
                ALUBusB = r_q[0] ? r_m : '0;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                Done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand load, per-iteration shift/accumulate and result capture.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_m       <= '0;
            r_q       <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (r_state == ST_IDLE) begin
            if (Start) begin
                r_m     <= MulA;
                r_q     <= MulB;
                r_acc   <= '0;
                r_count <= '0;
                if (MulB == '0) begin
                    r_product <= '0;
                end
            end
        end else if (w_run) begin
            r_acc   <= ALUBusW;
            r_m     <= r_m << 1;
            r_q     <= w_q_shr;
            r_count <= w_count_inc;
            if (w_last) begin
                r_product <= ALUBusW;
            end
        end
    end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle 64-bit unsigned multiply controller (low 64 bits of product) that sequences the shared datapath ALU using shift-and-add.
- Issues one ALU ADD per iteration and captures BusW, so no dedicated multiplier array is needed.
- Sits beside the ALU. While ALUOwn is high, the datapath's ALU input muxes select this block's ALUBusA, ALUBusB and ALUCtrlOut.

Parameters:
- WIDTH, 64, operand/product width; must match the ALU bus width.
- CNTW, 7, iteration counter width; equals clog2(WIDTH)+1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- MulA  input  WIDTH  multiplicand; captured on accepted Start.
- MulB  input  WIDTH  multiplier; captured on accepted Start.
- Busy  output  1  high while in RUN.
- Done  output  1  one-cycle pulse in DONE.
- Product  output  WIDTH  result register; holds until the next accepted Start.
- ALUOwn  output  1  high in RUN; requests the ALU mux.
- ALUCtrlOut  output  4  always the ADD code 4'b0010.
- ALUBusA  output  WIDTH  accumulator value.
- ALUBusB  output  WIDTH  M when Q[0]=1, else 0.
- ALUBusW  input  WIDTH  ALU result, combinational from ALUBusA/ALUBusB.

Behaviour:
- Reset (asynchronous, any state including mid-RUN):
  - state=IDLE.
  - Internal registers M, Q, Acc and count all cleared to 0.
  - Product=0, Busy=0, Done=0, ALUOwn=0.
  - Any operation in flight is abandoned; no Done is issued.
- States: IDLE, RUN, DONE. Outputs Busy, ALUOwn and Done are decoded from state.
- IDLE:
  - Start=1 at an edge: M<=MulA, Q<=MulB, Acc<=0, count<=0.
  - If MulB!=0, go to RUN. If MulB==0, go directly to DONE with Product<=0.
  - Start=0: remain in IDLE.
- RUN, one iteration per edge:
  - Acc<=ALUBusW (this is Acc+M when Q[0]=1, else Acc+0).
  - M<=M<<1 (bits shifted out are discarded). Q<=Q>>1. count<=count+1.
- RUN exit: if (Q>>1)==0 or count+1==WIDTH, then Product<=ALUBusW and go to DONE.
  - Iterations = 1 + index of the most-significant set bit of MulB, between 1 and WIDTH.
- DONE: lasts exactly one cycle with Done=1, then goes to IDLE. Start during DONE is ignored.
- Latency: let the Start edge be edge k and n be the iteration count.
  - Busy and ALUOwn are high for the cycles after edges k through k+n-1.
  - Done is high in the cycle after edge k+n, and Product is valid from that cycle on.
  - MulB==0: Done is high in the cycle after edge k.
- Start while RUN or DONE: ignored, no queueing. MulA/MulB are don't-care outside an accepted Start.
- Arithmetic: unsigned, modulo 2^WIDTH; overflow is silently truncated.
- ALU outputs outside RUN: ALUBusA=0, ALUBusB=0, ALUCtrlOut=ADD, so there is no X leakage.
- ALU Zero flag: not used.
- Product changes only on an accepted Start with MulB==0, on RUN exit, or on Reset.

Decomposition:
- Shared package holds:
  - ALU control codes: AND 0000, OR 0001, ADD 0010, SUB 0110, PassB 0111, MOVZ 0011. Both the ALU and this block use them.
  - State encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
- No sub-module. The ALU is external and shared; the counter and shift registers stay inline.

Test Plan:
- Reset=1 then released, no Start -> Product=0, Busy=0, Done=0, ALUOwn=0, ALUCtrlOut=0010 in every cycle.
- Start with MulA=3, MulB=5 at edge k -> Busy for 3 cycles; Done pulse in the cycle after edge k+3; Product=15 and stays 15 for 10 further idle cycles.
- Start with MulA=0x123, MulB=0 -> no RUN, Busy never high; Done in the cycle after the Start edge; Product=0.
- Start with MulA=0xFFFF_FFFF_FFFF_FFFF, MulB=0x8000_0000_0000_0000 -> 64 RUN cycles; Product=0x8000_0000_0000_0000 (truncation); Done 64 cycles after Start.
- Start with MulA=7, MulB=9; pulse Start again with MulA=1, MulB=1 during RUN and during DONE -> both ignored; Product=63.
- Start with MulA=10, MulB=0xFF; assert Reset after 3 RUN cycles -> all outputs 0 immediately, no Done; a new Start with 6*7 afterwards gives Product=42.
